slot_control_core: RTL and testbench
====================================

Name: slot_control_core

Overview:
Parametrised top-level control FSM for the audio record/play/mix datapath. It manages NUM_SLOTS fixed-size memory slots instead of one hard-wired buffer. It converts debounced key levels into one-cycle start, stop and pause commands for the record, play and mix engines, and tracks which slots hold recorded audio. It sits between the key/switch inputs and the engine cores, replacing the single-buffer controller.

Parameters:
NUM_SLOTS, 4, number of audio slots (2..8)
ADDR_W, 23, SRAM word-address width
SLOT_LEN, 2097152, words per slot; slot k base = k*SLOT_LEN; NUM_SLOTS*SLOT_LEN <= 2**ADDR_W (elaboration assertion)
SLOT_W, $clog2(NUM_SLOTS), slot index width (derived, not overridable)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_key_rec / i_key_play / i_key_stop / i_key_pause  in  1 each  debounced key levels, active-high
i_mix_req  in  1  mix request level (switch)
i_slot_sel  in  SLOT_W  target slot for record/play
i_mix_mask  in  NUM_SLOTS  slots to mix
o_mode  out  3  state code: 0 IDLE, 1 REC, 2 PLAY, 3 MIX, 4 STOPPING
o_rec_start / o_play_start / o_mix_start  out  1  one-cycle start pulses
o_stop  out  1  one-cycle stop pulse to the active engine
o_pause  out  1  pause level to the active engine
o_sel_base  out  ADDR_W  base address of latched slot (rec/play)
o_mix_sel  out  NUM_SLOTS*ADDR_W  packed mix base addresses, entry 0 in LSBs
o_mix_num  out  $clog2(NUM_SLOTS+1)  number of slots being mixed
o_slot_valid  out  NUM_SLOTS  slot k contains a completed recording
o_err  out  1  one-cycle pulse when a request is rejected
i_rec_done / i_play_done / i_mix_done  in  1 each  engine completion pulses

Behaviour:
- Reset: state IDLE; all pulses 0; o_pause 0; o_sel_base, o_mix_sel, o_mix_num 0; o_slot_valid all 0. Reset mid-operation aborts immediately. No stop is issued; engines are reset by the same i_rst.
- Key inputs are edge-detected internally: 1-cycle registered rising edge. Levels held high generate exactly one event. Key edges only, not levels, drive all transitions. i_mix_req is also edge-detected.
- IDLE, with simultaneous events, priority is rec > play > mix. Stop and pause are ignored in IDLE.
  - rec edge: latch slot=i_slot_sel. Go to REC. Next cycle o_rec_start=1 for 1 cycle, o_sel_base=slot*SLOT_LEN.
  - play edge: if o_slot_valid[i_slot_sel]=0, pulse o_err and stay IDLE. Otherwise latch slot, go to PLAY, pulse o_play_start one cycle later.
  - mix edge: reject with o_err if mask==0 or any masked slot is invalid. Otherwise compute o_mix_num=popcount(mask) and o_mix_sel. o_mix_sel is compacted in ascending slot order; unused entries are 0. Go to MIX, pulse o_mix_start next cycle. Mix outputs stay stable until return to IDLE.
  - If i_slot_sel is >= NUM_SLOTS (non-power-of-2 counts): pulse o_err, stay IDLE.
- REC/PLAY:
  - pause edge toggles o_pause.
  - stop edge: o_stop pulse, go to STOPPING.
  - Engine done: go to IDLE, clear o_pause.
  - Done and stop in the same cycle: done wins, no o_stop.
- REC completion, via done in REC or STOPPING-from-REC: set o_slot_valid[slot] on the same cycle as the transition to IDLE.
- REC start clears o_slot_valid[slot] on the o_rec_start cycle. A slot being overwritten is therefore invalid until its recording completes.
- MIX: pause is ignored. A stop edge gives o_stop and goes to STOPPING. i_mix_done returns to IDLE. The mix result is not stored to a slot.
- STOPPING: wait for the done of the engine that was active. o_pause is cleared on entry. Other done pulses are ignored. Keys are ignored.
- Done pulses in states that do not expect them are ignored.
- Latency: key edge at the input to start pulse is 2 cycles (edge register plus state register).
- o_mode is registered and reflects the current state.

Test Plan:
- Reset, then rec key with slot=2, then i_rec_done 100 cycles later: o_rec_start pulses once with o_sel_base=0x400000; o_mode goes 1 then 0; o_slot_valid=4'b0100.
- Play key on empty slot 1: o_err pulses 1 cycle, o_mode stays 0, no o_play_start. Play on slot 2: o_play_start pulses, pause key twice gives o_pause 1 then 0, stop gives o_stop then STOPPING, play_done gives IDLE.
- After recording slots 0 and 3, mix with mask=4'b1001: o_mix_num=2, o_mix_sel entry0=0, entry1=0x600000, entries 2-3=0. Mask 4'b1011 gives o_err.
- Rec, play and mix edges in the same cycle, with valid slot: REC entered; only o_rec_start pulses.
- Hold rec key high 50 cycles: exactly one o_rec_start. Stop and i_rec_done in the same cycle: no o_stop, IDLE, slot valid set.
- Assert i_rst during PAUSE'd PLAY: all outputs 0 and o_slot_valid cleared in the same cycle, asynchronously.

Source files
------------

// File: rtl/slot_control_core.sv
// slot_control_core: top-level record/play/mix sequencer over NUM_SLOTS
// fixed-size SRAM slots. Turns debounced key levels into one-cycle engine
// commands and tracks which slots hold a completed recording.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | no engine running; accepts rec/play/mix requests
// REC      | record engine writing latched slot; pause/stop/done honoured
// PLAY     | play engine reading latched slot; pause/stop/done honoured
// MIX      | mix engine reading masked slots; stop/done honoured
// STOPPING | stop issued; waiting for the done of the engine that ran
module slot_control_core #(
  parameter  int NUM_SLOTS = 4,
  parameter  int ADDR_W    = 23,
  parameter  int SLOT_LEN  = 2097152,
  localparam int SLOT_W    = $clog2(NUM_SLOTS),
  localparam int NUM_W     = $clog2(NUM_SLOTS + 1)
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_key_rec,
  input  logic                          i_key_play,
  input  logic                          i_key_stop,
  input  logic                          i_key_pause,
  input  logic                          i_mix_req,
  input  logic [SLOT_W-1:0]             i_slot_sel,
  input  logic [NUM_SLOTS-1:0]          i_mix_mask,
  input  logic                          i_rec_done,
  input  logic                          i_play_done,
  input  logic                          i_mix_done,
  output logic [2:0]                    o_mode,
  output logic                          o_rec_start,
  output logic                          o_play_start,
  output logic                          o_mix_start,
  output logic                          o_stop,
  output logic                          o_pause,
  output logic [ADDR_W-1:0]             o_sel_base,
  output logic [NUM_SLOTS*ADDR_W-1:0]   o_mix_sel,
  output logic [NUM_W-1:0]              o_mix_num,
  output logic [NUM_SLOTS-1:0]          o_slot_valid,
  output logic                          o_err
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_REC      = 3'd1;
  localparam logic [2:0] ST_PLAY     = 3'd2;
  localparam logic [2:0] ST_MIX      = 3'd3;
  localparam logic [2:0] ST_STOPPING = 3'd4;

  localparam int K_REC   = 0;
  localparam int K_PLAY  = 1;
  localparam int K_STOP  = 2;
  localparam int K_PAUSE = 3;
  localparam int K_MIX   = 4;

  if (NUM_SLOTS < 2 || NUM_SLOTS > 8) begin : g_bad_num_slots
    $error("slot_control_core: NUM_SLOTS must be in 2..8");
  end
  if (longint'(NUM_SLOTS) * longint'(SLOT_LEN) > (longint'(1) << ADDR_W)) begin : g_bad_slot_len
    $error("slot_control_core: NUM_SLOTS*SLOT_LEN exceeds the SRAM address space");
  end

  function automatic logic [ADDR_W-1:0] base_of(input int unsigned k);
    return ADDR_W'(longint'(k) * longint'(SLOT_LEN));
  endfunction

  logic [4:0] keys;
  logic [4:0] key_q;
  logic [4:0] edge_q;
  logic       slot_ok;

  assign keys = {i_mix_req, i_key_pause, i_key_stop, i_key_play, i_key_rec};

  // A selector beyond the last slot can only occur for non-power-of-2 counts.
  if (NUM_SLOTS == (1 << SLOT_W)) begin : g_slot_full
    assign slot_ok = 1'b1;
  end else begin : g_slot_partial
    assign slot_ok = (i_slot_sel < SLOT_W'(NUM_SLOTS));
  end

  logic [2:0]                  state_q, state_d;
  logic [2:0]                  from_q, from_d;
  logic [SLOT_W-1:0]           slot_q, slot_d;
  logic                        pause_q, pause_d;
  logic                        rec_start_q, rec_start_d;
  logic                        play_start_q, play_start_d;
  logic                        mix_start_q, mix_start_d;
  logic                        stop_q, stop_d;
  logic                        err_q, err_d;
  logic [ADDR_W-1:0]           sel_base_q, sel_base_d;
  logic [NUM_SLOTS*ADDR_W-1:0] mix_sel_q, mix_sel_d, mix_sel_c;
  logic [NUM_W-1:0]            mix_num_q, mix_num_d, mix_num_c;
  logic [NUM_SLOTS-1:0]        valid_q, valid_d;
  logic                        stop_done;

  // Compact the masked slot bases into ascending entries and count them.
  always_comb begin
    mix_sel_c = '0;
    mix_num_c = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (i_mix_mask[k]) begin
        mix_sel_c[int'(mix_num_c)*ADDR_W +: ADDR_W] = base_of(32'(k));
        mix_num_c = mix_num_c + NUM_W'(1);
      end
    end
  end

  // Only the done of the engine that was stopped ends STOPPING.
  always_comb begin
    case (from_q)
      ST_REC:  stop_done = i_rec_done;
      ST_PLAY: stop_done = i_play_done;
      ST_MIX:  stop_done = i_mix_done;
      default: stop_done = 1'b1;
    endcase
  end

  // Next-state and command decode; done outranks stop, stop outranks pause.
  always_comb begin
    state_d      = state_q;
    from_d       = from_q;
    slot_d       = slot_q;
    pause_d      = pause_q;
    rec_start_d  = 1'b0;
    play_start_d = 1'b0;
    mix_start_d  = 1'b0;
    stop_d       = 1'b0;
    err_d        = 1'b0;
    sel_base_d   = sel_base_q;
    mix_sel_d    = mix_sel_q;
    mix_num_d    = mix_num_q;
    valid_d      = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (edge_q[K_REC]) begin
          if (!slot_ok) begin
            err_d = 1'b1;
          end else begin
            state_d             = ST_REC;
            slot_d              = i_slot_sel;
            rec_start_d         = 1'b1;
            sel_base_d          = base_of(32'(i_slot_sel));
            valid_d[i_slot_sel] = 1'b0;
          end
        end else if (edge_q[K_PLAY]) begin
          if (!slot_ok || !valid_q[i_slot_sel]) begin
            err_d = 1'b1;
          end else begin
            state_d      = ST_PLAY;
            slot_d       = i_slot_sel;
            play_start_d = 1'b1;
            sel_base_d   = base_of(32'(i_slot_sel));
          end
        end else if (edge_q[K_MIX]) begin
          if (i_mix_mask == '0 || (i_mix_mask & ~valid_q) != '0) begin
            err_d = 1'b1;
          end else begin
            state_d     = ST_MIX;
            mix_start_d = 1'b1;
            mix_sel_d   = mix_sel_c;
            mix_num_d   = mix_num_c;
          end
        end
      end
      ST_REC, ST_PLAY: begin
        if ((state_q == ST_REC) ? i_rec_done : i_play_done) begin
          state_d = ST_IDLE;
          pause_d = 1'b0;
          if (state_q == ST_REC) valid_d[slot_q] = 1'b1;
        end else if (edge_q[K_STOP]) begin
          stop_d  = 1'b1;
          from_d  = state_q;
          state_d = ST_STOPPING;
          pause_d = 1'b0;
        end else if (edge_q[K_PAUSE]) begin
          pause_d = ~pause_q;
        end
      end
      ST_MIX: begin
        if (i_mix_done) begin
          state_d   = ST_IDLE;
          mix_sel_d = '0;
          mix_num_d = '0;
        end else if (edge_q[K_STOP]) begin
          stop_d  = 1'b1;
          from_d  = ST_MIX;
          state_d = ST_STOPPING;
        end
      end
      ST_STOPPING: begin
        if (stop_done) begin
          state_d = ST_IDLE;
          if (from_q == ST_REC) valid_d[slot_q] = 1'b1;
          if (from_q == ST_MIX) begin
            mix_sel_d = '0;
            mix_num_d = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Key edge pipeline plus all control registers; reset aborts immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      key_q        <= '0;
      edge_q       <= '0;
      state_q      <= ST_IDLE;
      from_q       <= ST_IDLE;
      slot_q       <= '0;
      pause_q      <= 1'b0;
      rec_start_q  <= 1'b0;
      play_start_q <= 1'b0;
      mix_start_q  <= 1'b0;
      stop_q       <= 1'b0;
      err_q        <= 1'b0;
      sel_base_q   <= '0;
      mix_sel_q    <= '0;
      mix_num_q    <= '0;
      valid_q      <= '0;
    end else begin
      key_q        <= keys;
      edge_q       <= keys & ~key_q;
      state_q      <= state_d;
      from_q       <= from_d;
      slot_q       <= slot_d;
      pause_q      <= pause_d;
      rec_start_q  <= rec_start_d;
      play_start_q <= play_start_d;
      mix_start_q  <= mix_start_d;
      stop_q       <= stop_d;
      err_q        <= err_d;
      sel_base_q   <= sel_base_d;
      mix_sel_q    <= mix_sel_d;
      mix_num_q    <= mix_num_d;
      valid_q      <= valid_d;
    end
  end

  assign o_mode       = state_q;
  assign o_rec_start  = rec_start_q;
  assign o_play_start = play_start_q;
  assign o_mix_start  = mix_start_q;
  assign o_stop       = stop_q;
  assign o_pause      = pause_q;
  assign o_sel_base   = sel_base_q;
  assign o_mix_sel    = mix_sel_q;
  assign o_mix_num    = mix_num_q;
  assign o_slot_valid = valid_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_slot_control_core.sv
// Bench for slot_control_core: directed scenarios then random key/done
// traffic, every cycle compared against a behavioural slot-controller model.
module tb_slot_control_core;

  localparam int NUM_SLOTS = 4;
  localparam int ADDR_W    = 23;
  localparam int SLOT_LEN  = 2097152;
  localparam int SLOT_W    = $clog2(NUM_SLOTS);
  localparam int NUM_W     = $clog2(NUM_SLOTS + 1);

  logic                        i_clk = 1'b0;
  logic                        i_rst = 1'b1;
  logic                        i_key_rec = 1'b0, i_key_play = 1'b0, i_key_stop = 1'b0;
  logic                        i_key_pause = 1'b0, i_mix_req = 1'b0;
  logic [SLOT_W-1:0]           i_slot_sel = '0;
  logic [NUM_SLOTS-1:0]        i_mix_mask = '0;
  logic                        i_rec_done = 1'b0, i_play_done = 1'b0, i_mix_done = 1'b0;
  logic [2:0]                  o_mode;
  logic                        o_rec_start, o_play_start, o_mix_start, o_stop, o_pause, o_err;
  logic [ADDR_W-1:0]           o_sel_base;
  logic [NUM_SLOTS*ADDR_W-1:0] o_mix_sel;
  logic [NUM_W-1:0]            o_mix_num;
  logic [NUM_SLOTS-1:0]        o_slot_valid;

  slot_control_core #(.NUM_SLOTS(NUM_SLOTS), .ADDR_W(ADDR_W), .SLOT_LEN(SLOT_LEN)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_key_rec(i_key_rec), .i_key_play(i_key_play), .i_key_stop(i_key_stop),
    .i_key_pause(i_key_pause), .i_mix_req(i_mix_req),
    .i_slot_sel(i_slot_sel), .i_mix_mask(i_mix_mask),
    .i_rec_done(i_rec_done), .i_play_done(i_play_done), .i_mix_done(i_mix_done),
    .o_mode(o_mode), .o_rec_start(o_rec_start), .o_play_start(o_play_start),
    .o_mix_start(o_mix_start), .o_stop(o_stop), .o_pause(o_pause),
    .o_sel_base(o_sel_base), .o_mix_sel(o_mix_sel), .o_mix_num(o_mix_num),
    .o_slot_valid(o_slot_valid), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Behavioural model: mode codes 0 idle, 1 rec, 2 play, 3 mix, 4 stopping.
  int                          m_mode, m_from, m_slot, m_mix_num;
  bit                          m_pause, m_rec_start, m_play_start, m_mix_start, m_stop, m_err;
  bit   [NUM_SLOTS-1:0]        m_valid;
  longint                      m_sel_base;
  logic [NUM_SLOTS*ADDR_W-1:0] m_mix_sel;
  bit                          m_evt[5];
  bit                          m_prev[5];

  task automatic model_reset();
    m_mode = 0; m_from = 0; m_slot = 0; m_mix_num = 0;
    m_pause = 0; m_rec_start = 0; m_play_start = 0; m_mix_start = 0; m_stop = 0; m_err = 0;
    m_valid = '0; m_sel_base = 0; m_mix_sel = '0;
    for (int k = 0; k < 5; k++) begin m_evt[k] = 0; m_prev[k] = 0; end
  endtask

  task automatic model_step();
    bit lv[5];
    int sel;
    bit done;
    longint bases[$];
    if (i_rst) begin model_reset(); return; end
    lv[0] = i_key_rec; lv[1] = i_key_play; lv[2] = i_key_stop; lv[3] = i_key_pause; lv[4] = i_mix_req;
    sel = int'(i_slot_sel);
    m_rec_start = 0; m_play_start = 0; m_mix_start = 0; m_stop = 0; m_err = 0;
    case (m_mode)
      0: begin
        if (m_evt[0]) begin
          if (sel >= NUM_SLOTS) m_err = 1;
          else begin
            m_mode = 1; m_slot = sel; m_rec_start = 1;
            m_sel_base = longint'(sel) * SLOT_LEN; m_valid[sel] = 0;
          end
        end else if (m_evt[1]) begin
          if (sel >= NUM_SLOTS || !m_valid[sel]) m_err = 1;
          else begin
            m_mode = 2; m_slot = sel; m_play_start = 1;
            m_sel_base = longint'(sel) * SLOT_LEN;
          end
        end else if (m_evt[4]) begin
          bit bad = (i_mix_mask == 0);
          for (int k = 0; k < NUM_SLOTS; k++) begin
            if (i_mix_mask[k]) begin
              if (!m_valid[k]) bad = 1;
              bases.push_back(longint'(k) * SLOT_LEN);
            end
          end
          if (bad) m_err = 1;
          else begin
            m_mode = 3; m_mix_start = 1; m_mix_num = bases.size(); m_mix_sel = '0;
            foreach (bases[i]) m_mix_sel[i*ADDR_W +: ADDR_W] = ADDR_W'(bases[i]);
          end
        end
      end
      1, 2: begin
        done = (m_mode == 1) ? i_rec_done : i_play_done;
        if (done) begin
          if (m_mode == 1) m_valid[m_slot] = 1;
          m_mode = 0; m_pause = 0;
        end else if (m_evt[2]) begin
          m_stop = 1; m_from = m_mode; m_mode = 4; m_pause = 0;
        end else if (m_evt[3]) m_pause = !m_pause;
      end
      3: begin
        if (i_mix_done) begin m_mode = 0; m_mix_sel = '0; m_mix_num = 0; end
        else if (m_evt[2]) begin m_stop = 1; m_from = 3; m_mode = 4; end
      end
      default: begin
        done = (m_from == 1) ? i_rec_done : (m_from == 2) ? i_play_done : i_mix_done;
        if (done) begin
          if (m_from == 1) m_valid[m_slot] = 1;
          if (m_from == 3) begin m_mix_sel = '0; m_mix_num = 0; end
          m_mode = 0;
        end
      end
    endcase
    for (int k = 0; k < 5; k++) begin
      m_evt[k]  = lv[k] && !m_prev[k];
      m_prev[k] = lv[k];
    end
  endtask

  task automatic compare_all();
    check("mode",       128'(o_mode),       128'(m_mode));
    check("rec_start",  128'(o_rec_start),  128'(m_rec_start));
    check("play_start", 128'(o_play_start), 128'(m_play_start));
    check("mix_start",  128'(o_mix_start),  128'(m_mix_start));
    check("stop",       128'(o_stop),       128'(m_stop));
    check("pause",      128'(o_pause),      128'(m_pause));
    check("err",        128'(o_err),        128'(m_err));
    check("sel_base",   128'(o_sel_base),   128'(m_sel_base));
    check("slot_valid", 128'(o_slot_valid), 128'(m_valid));
    if (m_mode == 3) begin
      check("mix_sel", 128'(o_mix_sel), 128'(m_mix_sel));
      check("mix_num", 128'(o_mix_num), 128'(m_mix_num));
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk);
      model_step();
      #1;
      compare_all();
    end
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0: i_key_rec = v;
      1: i_key_play = v;
      2: i_key_stop = v;
      3: i_key_pause = v;
      default: i_mix_req = v;
    endcase
  endtask

  task automatic press(input int k);
    set_key(k, 1'b1); tick(1);
    set_key(k, 1'b0); tick(1);
  endtask

  task automatic pulse_done(input int k);
    case (k)
      0: i_rec_done = 1'b1;
      1: i_play_done = 1'b1;
      default: i_mix_done = 1'b1;
    endcase
    tick(1);
    i_rec_done = 1'b0; i_play_done = 1'b0; i_mix_done = 1'b0;
  endtask

  task automatic record_slot(input int s);
    i_slot_sel = SLOT_W'(s);
    press(0);
    tick(3);
    pulse_done(0);
    tick(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int starts;
    logic [127:0] exp_mix;
    model_reset();
    tick(3);
    check("reset_mode",  128'(o_mode), 128'(0));
    check("reset_valid", 128'(o_slot_valid), 128'(0));
    check("reset_mix",   128'(o_mix_sel), 128'(0));
    i_rst = 1'b0;
    tick(2);

    // Record slot 2, complete 100 cycles later.
    i_slot_sel = 2'd2;
    press(0);
    check("rec_start_pulse", 128'(o_rec_start), 128'(1));
    check("rec_base",        128'(o_sel_base), 128'(23'h400000));
    check("rec_mode",        128'(o_mode), 128'(1));
    tick(100);
    pulse_done(0);
    check("rec_done_mode",  128'(o_mode), 128'(0));
    check("rec_done_valid", 128'(o_slot_valid), 128'(4'b0100));
    tick(2);

    // Play empty slot 1, then play slot 2 with pause/stop.
    i_slot_sel = 2'd1;
    press(1);
    check("play_empty_err",  128'(o_err), 128'(1));
    check("play_empty_mode", 128'(o_mode), 128'(0));
    tick(2);
    i_slot_sel = 2'd2;
    press(1);
    check("play_start_pulse", 128'(o_play_start), 128'(1));
    press(3);
    check("pause_on", 128'(o_pause), 128'(1));
    press(3);
    check("pause_off", 128'(o_pause), 128'(0));
    press(2);
    check("stop_pulse",    128'(o_stop), 128'(1));
    check("stopping_mode", 128'(o_mode), 128'(4));
    tick(3);
    pulse_done(1);
    check("play_stopped_idle", 128'(o_mode), 128'(0));
    tick(2);

    // Record slots 0 and 3, then mix.
    record_slot(0);
    record_slot(3);
    i_mix_mask = 4'b1001;
    press(4);
    exp_mix = 128'(23'h600000) << ADDR_W;
    check("mix_start_pulse", 128'(o_mix_start), 128'(1));
    check("mix_num",         128'(o_mix_num), 128'(2));
    check("mix_sel",         128'(o_mix_sel), exp_mix);
    tick(5);
    pulse_done(2);
    tick(2);
    i_mix_mask = 4'b1011;
    press(4);
    check("mix_invalid_err", 128'(o_err), 128'(1));
    tick(2);

    // Simultaneous rec/play/mix: rec wins.
    i_slot_sel = 2'd0;
    i_mix_mask = 4'b1001;
    i_key_rec = 1'b1; i_key_play = 1'b1; i_mix_req = 1'b1;
    tick(1);
    i_key_rec = 1'b0; i_key_play = 1'b0; i_mix_req = 1'b0;
    tick(1);
    check("prio_mode",       128'(o_mode), 128'(1));
    check("prio_rec_start",  128'(o_rec_start), 128'(1));
    check("prio_play_start", 128'(o_play_start), 128'(0));
    check("prio_mix_start",  128'(o_mix_start), 128'(0));
    tick(3);
    pulse_done(0);
    tick(2);

    // Held rec key gives one start; stop and done together: done wins.
    i_slot_sel = 2'd1;
    i_key_rec = 1'b1;
    starts = 0;
    for (int c = 0; c < 50; c++) begin
      tick(1);
      starts += int'(o_rec_start);
    end
    check("held_rec_starts", 128'(starts), 128'(1));
    i_key_stop = 1'b1;
    tick(1);
    i_key_stop = 1'b0;
    i_rec_done = 1'b1;
    tick(1);
    i_rec_done = 1'b0;
    check("stop_done_no_stop", 128'(o_stop), 128'(0));
    check("stop_done_idle",    128'(o_mode), 128'(0));
    check("stop_done_valid",   128'(o_slot_valid), 128'(4'b1111));
    i_key_rec = 1'b0;
    tick(2);

    // Asynchronous reset while paused in PLAY.
    i_slot_sel = 2'd2;
    press(1);
    press(3);
    check("pre_rst_pause", 128'(o_pause), 128'(1));
    check("pre_rst_mode",  128'(o_mode), 128'(2));
    #2;
    i_rst = 1'b1;
    #1;
    check("async_rst_mode",  128'(o_mode), 128'(0));
    check("async_rst_pause", 128'(o_pause), 128'(0));
    check("async_rst_valid", 128'(o_slot_valid), 128'(0));
    check("async_rst_base",  128'(o_sel_base), 128'(0));
    tick(2);
    i_rst = 1'b0;
    tick(2);

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      i_key_rec   = i_key_rec   ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 39) == 0);
      i_key_play  = i_key_play  ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 29) == 0);
      i_mix_req   = i_mix_req   ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 39) == 0);
      i_key_stop  = i_key_stop  ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 49) == 0);
      i_key_pause = i_key_pause ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0);
      i_rec_done  = ($urandom_range(0, 29) == 0);
      i_play_done = ($urandom_range(0, 29) == 0);
      i_mix_done  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 7) == 0) i_slot_sel = SLOT_W'($urandom_range(0, NUM_SLOTS - 1));
      if ($urandom_range(0, 7) == 0) i_mix_mask = NUM_SLOTS'($urandom_range(0, (1 << NUM_SLOTS) - 1));
      i_rst = ($urandom_range(0, 999) == 0);
      tick(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
